// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter and read sequencer for a shared 16x16 circular fifo.
// Two producers share the write port round-robin with a bounded burst; one consumer reads.
module fifo_wr_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned DW        = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req0,
    input  logic [DW-1:0] i_d0,
    input  logic          i_req1,
    input  logic [DW-1:0] i_d1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    input  logic          i_rd_req,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic          o_fifo_wr,
    output logic [DW-1:0] o_fifo_din,
    output logic          o_fifo_rd,
    input  logic          i_fifo_full,
    input  logic          i_fifo_empty,
    input  logic [DW-1:0] i_fifo_dout
);

    localparam logic [3:0] BurstLimit = 4'(MAX_BURST);
    localparam logic [3:0] CntSat     = 4'hF;

    logic       r_owner;
    logic [3:0] r_burst_cnt;
    logic       r_rd_valid;

    logic       w_owner_d;
    logic [3:0] w_burst_cnt_d;
    logic       w_pick;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_any_gnt;
    logic       w_gnt_idx;
    logic       w_fifo_rd;

    // Owner keeps the port until its burst budget is spent, then the waiting side wins.
    always_comb begin
        w_pick = (r_burst_cnt < BurstLimit) ? r_owner : ~r_owner;
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_reset && !i_fifo_full) begin
            if (i_req0 && !i_req1) begin
                w_gnt0 = 1'b1;
            end else if (i_req1 && !i_req0) begin
                w_gnt1 = 1'b1;
            end else if (i_req0 && i_req1) begin
                w_gnt0 = ~w_pick;
                w_gnt1 = w_pick;
            end
        end
    end

    always_comb begin
        w_any_gnt = w_gnt0 | w_gnt1;
        w_gnt_idx = w_gnt1;
    end

    always_comb begin
        w_owner_d     = r_owner;
        w_burst_cnt_d = r_burst_cnt;
        if (w_any_gnt) begin
            if (w_gnt_idx == r_owner) begin
                w_burst_cnt_d = (r_burst_cnt == CntSat) ? CntSat : r_burst_cnt + 4'd1;
            end else begin
                w_owner_d     = w_gnt_idx;
                w_burst_cnt_d = 4'd1;
            end
        end
    end

    always_comb begin
        w_fifo_rd = i_rd_req & ~i_fifo_empty & i_reset;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_owner     <= 1'b0;
            r_burst_cnt <= 4'd0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_owner     <= w_owner_d;
            r_burst_cnt <= w_burst_cnt_d;
            r_rd_valid  <= w_fifo_rd;
        end
    end

    always_comb begin
        o_gnt0     = w_gnt0;
        o_gnt1     = w_gnt1;
        o_fifo_wr  = w_any_gnt;
        o_fifo_din = w_gnt1 ? i_d1 : i_d0;
        o_fifo_rd  = w_fifo_rd;
        o_rd_valid = r_rd_valid;
        o_rd_data  = i_fifo_dout;
    end

    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_reset) !(o_gnt0 && o_gnt1));
    a_no_wr_full: assert property (@(posedge i_clk) disable iff (!i_reset)
                                   !(o_fifo_wr && i_fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter, paired with a behavioural 16-entry fifo
// that has registered read data.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst_n;
    logic          fifo_rst_n;
    logic          req0, req1, rd_req;
    logic [DW-1:0] d0, d1;
    logic          gnt0, gnt1, rd_valid, fifo_wr, fifo_rd;
    logic [DW-1:0] rd_data, fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(
        .MAX_BURST(4),
        .DW       (DW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req0      (req0),
        .i_d0        (d0),
        .i_req1      (req1),
        .i_d1        (d1),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .i_rd_req    (rd_req),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_fifo_wr   (fifo_wr),
        .o_fifo_din  (fifo_din),
        .o_fifo_rd   (fifo_rd),
        .i_fifo_full (fifo_full),
        .i_fifo_empty(fifo_empty),
        .i_fifo_dout (fifo_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16x16 circular fifo with one-cycle read latency.
    logic [DW-1:0] mem [16];
    logic [4:0]    cnt;
    logic [3:0]    wp, rp;
    assign fifo_full  = (cnt == 5'd16);
    assign fifo_empty = (cnt == 5'd0);

    always_ff @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            cnt       <= '0;
            wp        <= '0;
            rp        <= '0;
            fifo_dout <= '0;
        end else begin
            if (fifo_wr && !fifo_full) begin
                mem[wp] <= fifo_din;
                wp      <= wp + 4'd1;
            end
            if (fifo_rd && !fifo_empty) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 4'd1;
            end
            case ({fifo_wr && !fifo_full, fifo_rd && !fifo_empty})
                2'b10:   cnt <= cnt + 5'd1;
                2'b01:   cnt <= cnt - 5'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fifo_rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; d0 = '0; d1 = '0;
        tick();
        tick();
        rst_n      = 1'b1;
        fifo_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fifo_rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1; d0 = 16'h5555; d1 = 16'hAAAA;
        tick();
        @(negedge clk);
        n_checks++; if (gnt0 !== 1'b0) begin n_errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
        n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
        n_checks++; if (fifo_wr !== 1'b0) begin n_errors++; $display("FAIL reset_fifo_wr: got %b want 0", fifo_wr); end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (fifo_rd !== 1'b0) begin n_errors++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
    endtask

    task automatic test_single_write();
        do_reset();
        req0 = 1'b1; d0 = 16'hA001;
        @(negedge clk);
        n_checks++; if (gnt0 !== 1'b1) begin n_errors++; $display("FAIL single_gnt0: got %b want 1", gnt0); end
        n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("FAIL single_gnt1: got %b want 0", gnt1); end
        n_checks++; if (fifo_wr !== 1'b1) begin n_errors++; $display("FAIL single_fifo_wr: got %b want 1", fifo_wr); end
        n_checks++; if (fifo_din !== 16'hA001) begin n_errors++; $display("FAIL single_fifo_din: got %h want a001", fifo_din); end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        n_checks++; if (dut.r_owner !== 1'b0) begin n_errors++; $display("FAIL single_owner: got %b want 0", dut.r_owner); end
        n_checks++; if (dut.r_burst_cnt !== 4'd1) begin n_errors++; $display("FAIL single_burst_cnt: got %0d want 1", dut.r_burst_cnt); end
        n_checks++; if (fifo_wr !== 1'b0) begin n_errors++; $display("FAIL single_idle_wr: got %b want 0", fifo_wr); end
    endtask

    task automatic test_round_robin();
        logic [8:0] exp_seq;
        exp_seq = 9'b0_1111_0000;   // bit i is the expected grantee on cycle i
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            d0 = 16'h0D00 + 16'(i);
            d1 = 16'h1D00 + 16'(i);
            @(negedge clk);
            n_checks++;
            if (gnt0 !== ~exp_seq[i] || gnt1 !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL rr_grant[%0d]: got gnt0=%b gnt1=%b want grantee %0d", i, gnt0, gnt1, exp_seq[i]);
            end
            n_checks++;
            if (fifo_din !== (exp_seq[i] ? d1 : d0)) begin
                n_errors++;
                $display("FAIL rr_din[%0d]: got %h want %h", i, fifo_din, exp_seq[i] ? d1 : d0);
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d1 = 16'hC000 + 16'(i);
            @(negedge clk);
            n_checks++; if (gnt1 !== 1'b1) begin n_errors++; $display("FAIL fill_gnt1[%0d]: got %b want 1", i, gnt1); end
            tick();
        end
        d1 = 16'hC0FF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("FAIL full_gnt1[%0d]: got %b want 0", i, gnt1); end
            n_checks++; if (fifo_wr !== 1'b0) begin n_errors++; $display("FAIL full_fifo_wr[%0d]: got %b want 0", i, fifo_wr); end
            tick();
        end
        rd_req = 1'b1;
        @(negedge clk);
        n_checks++; if (fifo_rd !== 1'b1) begin n_errors++; $display("FAIL full_fifo_rd: got %b want 1", fifo_rd); end
        n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("FAIL full_rd_gnt1: got %b want 0", gnt1); end
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL full_rd_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 16'hC000) begin n_errors++; $display("FAIL full_rd_data: got %h want c000", rd_data); end
        n_checks++; if (gnt1 !== 1'b1) begin n_errors++; $display("FAIL unfull_gnt1: got %b want 1", gnt1); end
        n_checks++; if (fifo_din !== 16'hC0FF) begin n_errors++; $display("FAIL unfull_din: got %h want c0ff", fifo_din); end
        tick();
        req1 = 1'b0;
    endtask

    task automatic test_empty_read();
        do_reset();
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (fifo_rd !== 1'b0) begin n_errors++; $display("FAIL empty_fifo_rd[%0d]: got %b want 0", i, fifo_rd); end
            n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_rd_valid[%0d]: got %b want 0", i, rd_valid); end
            tick();
        end
        rd_req = 1'b0; req0 = 1'b1; d0 = 16'h1234;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_rd_valid_after: got %b want 0", rd_valid); end
        n_checks++; if (gnt0 !== 1'b1) begin n_errors++; $display("FAIL empty_wr_gnt0: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0; rd_req = 1'b1;
        @(negedge clk);
        n_checks++; if (fifo_rd !== 1'b1) begin n_errors++; $display("FAIL empty_then_rd: got %b want 1", fifo_rd); end
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL empty_then_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 16'h1234) begin n_errors++; $display("FAIL empty_then_data: got %h want 1234", rd_data); end
        tick();
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_valid_drop: got %b want 0", rd_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d1 = 16'hE000 + 16'(i);
            rd_req = (i == 2);
            tick();
        end
        req0 = 1'b1;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL async_pre_valid: got %b want 1", rd_valid); end
        n_checks++; if (dut.r_owner !== 1'b1 || dut.r_burst_cnt !== 4'd3) begin
            n_errors++; $display("FAIL async_pre_state: got owner=%b cnt=%0d want owner=1 cnt=3", dut.r_owner, dut.r_burst_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL async_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_errors++; $display("FAIL async_gnts: got %b%b want 00", gnt0, gnt1); end
        n_checks++; if (fifo_rd !== 1'b0) begin n_errors++; $display("FAIL async_fifo_rd: got %b want 0", fifo_rd); end
        tick();
        rd_req = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_errors++; $display("FAIL async_release: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
        tick();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_burst_saturation();
        do_reset();
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d1 = 16'hF000 + 16'(i);
            @(negedge clk);
            n_checks++; if (gnt1 !== 1'b1) begin n_errors++; $display("FAIL solo_gnt1[%0d]: got %b want 1", i, gnt1); end
            tick();
        end
        req0 = 1'b1; d0 = 16'h0F0F;
        @(negedge clk);
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_errors++; $display("FAIL sat_switch: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
        n_checks++; if (fifo_din !== 16'h0F0F) begin n_errors++; $display("FAIL sat_din: got %h want 0f0f", fifo_din); end
        tick();
        @(negedge clk);
        n_checks++; if (dut.r_owner !== 1'b0 || dut.r_burst_cnt !== 4'd1) begin
            n_errors++; $display("FAIL sat_state: got owner=%b cnt=%0d want owner=0 cnt=1", dut.r_owner, dut.r_burst_cnt);
        end
        n_checks++; if (gnt0 !== 1'b1) begin n_errors++; $display("FAIL sat_keep_owner: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; fifo_rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; d0 = '0; d1 = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_full();
        test_empty_read();
        test_async_reset();
        test_burst_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Sits in front of the 16x16 circular-queue fifo and shares its single write port between two producers (req0/req1) using round-robin arbitration with a bounded burst length.
- Also sequences the fifo read port for one consumer: it issues the read strobe and generates a valid flag that is aligned with the fifo's registered output.
- Drives fifo wr/rd/d_in and consumes fifo full/empty/d_out.

Parameters:
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15.
- DW, 16, data width; must match the fifo.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  producer 0 write request; held until granted.
- d0  in  DW  producer 0 write data.
- req1  in  1  producer 1 write request; held until granted.
- d1  in  DW  producer 1 write data.
- gnt0  out  1  producer 0 grant; combinational; write accepted this cycle.
- gnt1  out  1  producer 1 grant; combinational.
- rd_req  in  1  consumer read request.
- rd_valid  out  1  registered; rd_data is valid this cycle.
- rd_data  out  DW  equals fifo_dout.
- fifo_wr  out  1  to fifo wr; equals gnt0|gnt1.
- fifo_din  out  DW  d0 when gnt0, d1 when gnt1, else d0.
- fifo_rd  out  1  to fifo rd.
- fifo_full  in  1  from fifo.
- fifo_empty  in  1  from fifo.
- fifo_dout  in  DW  from fifo; registered, one-cycle read latency.

Behaviour:
- State:
  - owner (1 bit): last granted requester.
  - burst_cnt (4 bits): consecutive grants to owner.
  - rd_valid flop.
- Reset (reset=0, asynchronous, effective immediately even mid-transfer): owner=0, burst_cnt=0, rd_valid=0.
  - Combinational outputs follow from this state: gnt0=gnt1=0 whenever reset=0.
  - Released on the first clk edge with reset=1.
- Write arbitration (combinational, per cycle):
  - fifo_full=1 -> gnt0=gnt1=0; state held.
  - Only reqX=1 -> gntX=1, regardless of owner or burst_cnt.
  - Both requesting, burst_cnt < MAX_BURST -> grant owner.
  - Both requesting, burst_cnt >= MAX_BURST -> grant the non-owner.
  - gnt0 and gnt1 are never both 1 (one-hot or zero).
- State update on a granted cycle, granted index g:
  - g==owner -> burst_cnt <= burst_cnt+1, saturating at 15.
  - g!=owner -> owner <= g, burst_cnt <= 1.
- No grant (idle or full) -> owner and burst_cnt unchanged.
- Read sequencing:
  - fifo_rd = rd_req & ~fifo_empty & reset.
  - rd_valid <= fifo_rd, so data appears one cycle after the strobe.
  - rd_data = fifo_dout (pass-through); the consumer samples only when rd_valid=1.
  - rd_req while fifo_empty=1 -> no strobe, and rd_valid=0 next cycle.
  - Back-to-back rd_req with data available -> fifo_rd every cycle and rd_valid every cycle from the second cycle on.
- Simultaneous read and write in the same cycle are both issued; the fifo handles them independently.
- No additional occupancy tracking; full/empty come solely from the fifo.
- Full boundary: a write request that arrives while full stays pending and is granted in the first cycle full deasserts.
  - If both producers are waiting at that point, the normal priority rule applies.
- Write order into the fifo equals grant order.

Test Plan:
- Reset, then req0=1, d0=16'hA001 for 1 cycle -> gnt0=1, fifo_wr=1, fifo_din=16'hA001; then owner=0, burst_cnt=1.
- req0=req1=1 continuously from reset, MAX_BURST=4, fifo not full -> grant sequence 0,0,0,0,1,1,1,1,0,... (4/4 alternation); never both grants high.
- Fill the fifo until fifo_full=1 with req1 held -> gnt1=0 while full. Then assert rd_req for 1 cycle -> fifo_rd=1, rd_valid=1 next cycle with the oldest word. The cycle after full drops, gnt1=1.
- rd_req=1 with fifo_empty=1 for 3 cycles -> fifo_rd=0, rd_valid=0 throughout. Then write 16'h1234 -> next rd_req gives fifo_rd, and rd_valid=1 with rd_data=16'h1234 one cycle later.
- Assert reset=0 asynchronously mid-burst (owner=1, burst_cnt=3, rd_valid=1) -> rd_valid=0 immediately, gnt0=gnt1=0, fifo_rd=0. After release with both requesting, first grant goes to req0.
- req1 alone for 6 cycles, then both requesting, MAX_BURST=4 -> burst_cnt saturated at 6 >= 4, so req0 is granted immediately; owner=0, burst_cnt=1.
